// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state encoding and read/write direction codes for the memory unit
package mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2, HOLD = 2'd3} state_t;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with a registered, clearable read port
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (clr) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_mfc_unit.sv
// mem_mfc_unit: MAR/MBR memory slave with fixed per-direction latency and four-phase mfc handshake
module mem_mfc_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mar_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              mbr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enable,
  input  logic              rw,
  output logic              mfc,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, lat;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic rw_q, rw_e, in_range, go_done, idle;
  assign idle     = state == IDLE;
  assign rw_e     = idle ? rw : rw_q;
  assign lat      = rw ? CW'(RD_LAT) : CW'(WR_LAT);
  assign in_range = {1'b0, mar} < LIM;
  assign go_done  = reset && state_n == DONE && state != DONE;
  assign mfc      = state == DONE;
  assign busy     = state == WAIT || state == DONE;
  assign err      = mfc && !in_range;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        state_n = !enable ? IDLE : lat == CW'(1) ? DONE : WAIT;
        cnt_n   = enable ? lat - 1'b1 : cnt;
      end
      WAIT: begin
        state_n = !enable ? IDLE : cnt == CW'(1) ? DONE : WAIT;
        cnt_n   = cnt - 1'b1;
      end
      DONE:    state_n = enable ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rw_q  <= RW_READ;
      mar   <= '0;
      mbr   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (idle && enable) rw_q <= rw;
      if (idle && mar_en) mar <= addr_in;
      if (idle && mbr_en) mbr <= data_in;
    end
  end
  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (go_done && rw_e == RW_WRITE && in_range),
    .re    (go_done && rw_e == RW_READ && in_range),
    .clr   (!reset || (go_done && rw_e == RW_READ && !in_range)),
    .addr  (mar),
    .wdata (mbr),
    .rdata (data_out)
  );
endmodule

// File: tb/tb_mem_mfc_unit.sv
// tb_mem_mfc_unit: directed and randomized accesses checked against a word-array memory model
module tb_mem_mfc_unit;
  localparam int DEPTH = 200;
  logic clk = 0, reset = 0, mar_en = 0, mbr_en = 0, enable = 0, rw = 0;
  logic [7:0]  addr_in = 0;
  logic [15:0] data_in = 0;
  logic        mfc, busy, err;
  logic [15:0] data_out;
  int n_chk = 0, n_pass = 0;
  logic [15:0] ram_m [256];
  bit          known [256];
  logic [15:0] dout_m = 0;
  always #5 clk = ~clk;
  mem_mfc_unit #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .RD_LAT(2), .WR_LAT(3)) dut (
    .clk(clk), .reset(reset), .mar_en(mar_en), .addr_in(addr_in), .mbr_en(mbr_en),
    .data_in(data_in), .enable(enable), .rw(rw), .mfc(mfc), .data_out(data_out),
    .busy(busy), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    mar_en = 1; mbr_en = 1; addr_in = a; data_in = d;
    @(negedge clk);
    mar_en = 0; mbr_en = 0; addr_in = 8'($urandom); data_in = 16'($urandom);
  endtask
  task automatic access(input logic r, input logic [7:0] a, input logic [15:0] d,
                        input int hold, input bit poke);
    int edges;
    bit oor;
    edges = 0;
    oor = a >= DEPTH;
    load(a, d);
    enable = 1; rw = r;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      rw = 1'($urandom);
      mar_en = poke && edges == 1; mbr_en = mar_en;
      addr_in = 8'h55; data_in = 16'hFFFF;
    end while (!mfc && edges < 10);
    mar_en = 0; mbr_en = 0;
    chk("latency", edges, r ? 2 : 3);
    chk("err", err, oor);
    chk("busy", busy, 1);
    if (r) dout_m = oor ? 16'h0 : ram_m[a];
    else if (!oor) begin ram_m[a] = d; known[a] = 1; end
    chk("data_out", data_out, dout_m);
    repeat (hold) begin
      @(negedge clk);
      chk("mfc_hold", mfc, 1);
      chk("data_hold", data_out, dout_m);
    end
    enable = 0;
    @(negedge clk);
    chk("mfc_drop", mfc, 0);
    chk("busy_idle", busy, 0);
    chk("err_clr", err, 0);
  endtask
  initial begin
    logic [7:0] a;
    logic r;
    repeat (2) @(negedge clk);
    chk("rst_mfc", mfc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", data_out, 0);
    reset = 1;
    access(0, 8'h10, 16'hBEEF, 0, 0);
    access(1, 8'h10, 16'h0000, 5, 0);
    access(0, 8'h20, 16'h5A5A, 0, 0);
    load(8'h20, 16'hDEAD);
    enable = 1; rw = 0;
    @(negedge clk);
    enable = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_mfc", mfc, 0);
    end
    chk("abort_busy", busy, 0);
    chk("abort_dout", data_out, dout_m);
    access(1, 8'h20, 16'h0, 0, 0);
    access(0, 8'h30, 16'h1111, 0, 0);
    load(8'h30, 16'h2222);
    enable = 1; rw = 0;
    repeat (2) @(negedge clk);
    reset = 0; enable = 0;
    repeat (2) @(negedge clk);
    chk("rstw_mfc", mfc, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_err", err, 0);
    chk("rstw_dout", data_out, 0);
    dout_m = 0;
    reset = 1;
    access(1, 8'h30, 16'h0, 0, 0);
    access(0, 8'd250, 16'h1234, 0, 0);
    access(1, 8'd250, 16'h0, 1, 0);
    access(1, 8'h10, 16'h0, 0, 0);
    access(0, 8'h55, 16'h7777, 0, 0);
    access(0, 8'h40, 16'hCAFE, 0, 1);
    access(1, 8'h40, 16'h0, 0, 0);
    access(1, 8'h55, 16'h0, 0, 0);
    repeat (80) begin
      a = 8'($urandom_range(0, 255));
      r = 1'($urandom);
      if (r && a < DEPTH && !known[a]) r = 0;
      access(r, a, 16'($urandom), $urandom_range(0, 3), !r && $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
